// File: rtl/mult4u_share_arb_pkg.sv
// Shared widths, pipeline stage records and Booth digit encoding for mult4u_share_arb.
package mult4u_share_arb_pkg;

  localparam int unsigned OP_W     = 4;
  localparam int unsigned PROD_W   = 8;
  localparam int unsigned ID_MAX_W = 3;

  typedef struct packed {
    logic                valid;
    logic [ID_MAX_W-1:0] id;
    logic [OP_W-1:0]     mcand;
    logic [OP_W-1:0]     mplier;
  } s1_stage_t;

  typedef struct packed {
    logic                valid;
    logic [ID_MAX_W-1:0] id;
    logic [PROD_W-1:0]   product;
  } s2_stage_t;

  typedef enum logic [2:0] {
    BOOTH_ZERO,
    BOOTH_P1,
    BOOTH_P2,
    BOOTH_M1,
    BOOTH_M2
  } booth_digit_e;

  // Radix-4 Booth recoding of the triplet {b(2k+1), b(2k), b(2k-1)}.
  function automatic booth_digit_e booth_encode(input logic [2:0] trip);
    booth_digit_e d;
    case (trip)
      3'b001, 3'b010: d = BOOTH_P1;
      3'b011:         d = BOOTH_P2;
      3'b100:         d = BOOTH_M2;
      3'b101, 3'b110: d = BOOTH_M1;
      default:        d = BOOTH_ZERO;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/mult4u_booth4_sklansky.sv
// Combinational 4x4 unsigned multiplier: radix-4 Booth partial products summed with Sklansky prefix adders.
module mult4u_booth4_sklansky
  import mult4u_share_arb_pkg::*;
(
  input  logic [OP_W-1:0]   mcand_i,
  input  logic [OP_W-1:0]   mplier_i,
  output logic [PROD_W-1:0] product_o
);

  localparam int unsigned NUM_PP = 3;
  localparam int unsigned LVLS   = $clog2(PROD_W);

  function automatic logic [PROD_W-1:0] sklansky_add(input logic [PROD_W-1:0] x,
                                                    input logic [PROD_W-1:0] y);
    logic [PROD_W-1:0] g;
    logic [PROD_W-1:0] p;
    int unsigned       j;
    g = x & y;
    p = x ^ y;
    j = 0;
    // Node j always has bit l clear, so it is never rewritten in the same level.
    for (int unsigned l = 0; l < LVLS; l++) begin
      for (int unsigned i = 0; i < PROD_W; i++) begin
        if (((i >> l) & 1) == 1) begin
          j    = ((i >> (l + 1)) << (l + 1)) + (1 << l) - 1;
          g[i] = g[i] | (p[i] & g[j]);
          p[i] = p[i] & p[j];
        end
      end
    end
    return (x ^ y) ^ {g[PROD_W-2:0], 1'b0};
  endfunction

  logic [6:0]        mplier_ext;
  logic [PROD_W-1:0] pp [NUM_PP];
  logic [PROD_W-1:0] sum01;

  assign mplier_ext = {2'b00, mplier_i, 1'b0};

  always_comb begin
    booth_digit_e      d;
    logic [PROD_W-1:0] mag;
    logic [PROD_W-1:0] val;
    d   = BOOTH_ZERO;
    mag = '0;
    val = '0;
    for (int unsigned k = 0; k < NUM_PP; k++) begin
      d   = booth_encode(mplier_ext[2*k +: 3]);
      mag = (d == BOOTH_P2 || d == BOOTH_M2) ? {3'b000, mcand_i, 1'b0}
                                             : {4'b0000, mcand_i};
      case (d)
        BOOTH_P1, BOOTH_P2: val = mag;
        BOOTH_M1, BOOTH_M2: val = ~mag + 8'd1;
        default:            val = '0;
      endcase
      pp[k] = val << (2 * k);
    end
  end

  assign sum01     = sklansky_add(pp[0], pp[1]);
  assign product_o = sklansky_add(sum01, pp[2]);

endmodule

// File: rtl/mult4u_share_arb.sv
// NUM_REQ requesters share one 4x4 multiplier through a two-stage valid/ready pipeline.
// Define MULT4U_SHARE_ARB_FIXED_PRIO_EN for lowest-index-wins arbitration instead of round-robin.
module mult4u_share_arb
  import mult4u_share_arb_pkg::*;
#(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [OP_W*NUM_REQ-1:0] req_multiplicand,
  input  logic [OP_W*NUM_REQ-1:0] req_multiplier,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [PROD_W-1:0]       out_product,
  output logic [ID_W-1:0]         out_id,
  output logic [1:0]              occupancy
);

  s1_stage_t         s1_q, s1_d;
  s2_stage_t         s2_q, s2_d;
  logic              s1_adv, s2_adv;
  logic              any_req, accept;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]   gid;
  logic [ID_W-1:0]   search_start;
  logic [PROD_W-1:0] mult_p;

  assign s2_adv = !s2_q.valid | out_ready;
  assign s1_adv = !s1_q.valid | s2_adv;
  assign accept = any_req & s1_adv & rst_n;

`ifdef MULT4U_SHARE_ARB_FIXED_PRIO_EN
  assign search_start = '0;
`else
  logic [ID_W-1:0] rr_q, rr_d;

  always_comb begin
    rr_d = rr_q;
    if (accept) begin
      rr_d = (gid == ID_W'(NUM_REQ - 1)) ? '0 : gid + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_q <= '0;
    else        rr_q <= rr_d;
  end

  assign search_start = rr_q;
`endif

  always_comb begin
    int unsigned idx;
    idx     = 0;
    any_req = 1'b0;
    gid     = '0;
    grant   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = (int'(search_start) + k) % NUM_REQ;
      if (!any_req && req_valid[idx]) begin
        any_req = 1'b1;
        gid     = ID_W'(idx);
      end
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      grant[i] = any_req && (gid == ID_W'(i));
    end
  end

  // Gated by rst_n so no requester sees an accept while reset is held.
  assign req_ready = grant & {NUM_REQ{s1_adv & rst_n}};

  always_comb begin
    s1_d = s1_q;
    if (s1_adv) begin
      s1_d.valid = accept;
      if (accept) begin
        s1_d.id     = ID_MAX_W'(gid);
        s1_d.mcand  = req_multiplicand[int'(gid)*OP_W +: OP_W];
        s1_d.mplier = req_multiplier[int'(gid)*OP_W +: OP_W];
      end
    end
  end

  mult4u_booth4_sklansky u_mult (
    .mcand_i   (s1_q.mcand),
    .mplier_i  (s1_q.mplier),
    .product_o (mult_p)
  );

  always_comb begin
    s2_d = s2_q;
    if (s2_adv) begin
      s2_d.valid = s1_q.valid;
      if (s1_q.valid) begin
        s2_d.id      = s1_q.id;
        s2_d.product = mult_p;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign out_valid   = s2_q.valid;
  assign out_product = s2_q.product;
  assign out_id      = s2_q.id[ID_W-1:0];
  assign occupancy   = {1'b0, s1_q.valid} + {1'b0, s2_q.valid};

endmodule

// File: tb/tb_mult4u_share_arb.sv
// Self-checking bench for mult4u_share_arb: vector table, directed corner sequences, randomized model run.
module tb_mult4u_share_arb;

  localparam int unsigned N = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_ready;
  logic [4*N-1:0] req_multiplicand;
  logic [4*N-1:0] req_multiplier;
  logic          out_valid;
  logic          out_ready;
  logic [7:0]    out_product;
  logic [1:0]    out_id;
  logic [1:0]    occupancy;

  int vectors     = 0;
  int miscompares = 0;

  mult4u_share_arb #(.NUM_REQ(N)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_multiplicand (req_multiplicand),
    .req_multiplier   (req_multiplier),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_product      (out_product),
    .out_id           (out_id),
    .occupancy        (occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int       id;
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] exp_p;
  } vec_t;

  typedef struct {
    int id;
    int prod;
  } item_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int id, input logic [3:0] a, input logic [3:0] b);
    req_multiplicand[id*4 +: 4] = a;
    req_multiplier[id*4 +: 4]   = b;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '1;
    out_ready = 1'b1;
    #1;
    chk("rst_ready", req_ready, 0);
    chk("rst_ovalid", out_valid, 0);
    chk("rst_prod", out_product, 0);
    chk("rst_id", out_id, 0);
    chk("rst_occ", occupancy, 0);
    req_valid = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  vec_t  vecs [8];
  item_t exp_q [$];
  int    prods [4];

  initial begin
    int    ptr, n, w, found, idx, acc_last, exp_ov, allowed;
    logic [N-1:0] exp_ready;

    req_valid        = '0;
    req_multiplicand = '0;
    req_multiplier   = '0;
    out_ready        = 1'b1;
    rst_n            = 1'b0;

    vecs[0] = '{2, 4'd7,  4'd9,  8'd63};
    vecs[1] = '{0, 4'd15, 4'd15, 8'd225};
    vecs[2] = '{1, 4'd0,  4'd15, 8'd0};
    vecs[3] = '{3, 4'd1,  4'd1,  8'd1};
    vecs[4] = '{2, 4'd15, 4'd0,  8'd0};
    vecs[5] = '{1, 4'd12, 4'd10, 8'd120};
    vecs[6] = '{3, 4'd9,  4'd14, 8'd126};
    vecs[7] = '{0, 4'd8,  4'd8,  8'd64};
    prods   = '{15, 24, 35, 48};

    // Table: single requests, 2-cycle latency, operands sampled only at accept.
    do_reset();
    for (int v = 0; v < 8; v++) begin
      req_multiplicand = 16'($urandom);
      req_multiplier   = 16'($urandom);
      set_ops(vecs[v].id, vecs[v].a, vecs[v].b);
      req_valid = N'(1) << vecs[v].id;
      out_ready = 1'b1;
      #1;
      chk("tbl_ready", req_ready, N'(1) << vecs[v].id);
      tick();
      req_valid        = '0;
      req_multiplicand = 16'($urandom);
      req_multiplier   = 16'($urandom);
      #1;
      chk("tbl_lat1_ovalid", out_valid, 0);
      chk("tbl_lat1_occ", occupancy, 1);
      tick();
      chk("tbl_lat2_ovalid", out_valid, 1);
      chk("tbl_prod", out_product, vecs[v].exp_p);
      chk("tbl_id", out_id, vecs[v].id);
      tick();
    end

    // Round-robin with all four requesting continuously.
    do_reset();
    for (int i = 0; i < 4; i++) set_ops(i, 4'(i + 3), 4'(i + 5));
    req_valid = '1;
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k == 5) req_valid = '0;
      #1;
      if (k < 5) chk("rr_ready", req_ready, N'(1) << (k % 4));
      chk("rr_ovalid", out_valid, (k >= 2) ? 1 : 0);
      if (k >= 2) begin
        chk("rr_id", out_id, k - 2);
        chk("rr_prod", out_product, prods[k-2]);
      end
      tick();
    end
    tick();
    tick();

    // Stall: two results queued while out_ready is low for 5 cycles.
    do_reset();
    set_ops(0, 4'd2, 4'd3);
    set_ops(1, 4'd4, 4'd5);
    req_valid = 4'b0011;
    out_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (k == 5) begin
        req_valid = '0;
        out_ready = 1'b1;
      end
      #1;
      if (k == 0) chk("stall_ready0", req_ready, 4'b0001);
      if (k == 1) chk("stall_ready1", req_ready, 4'b0010);
      if (k >= 2 && k <= 4) begin
        chk("stall_occ", occupancy, 2);
        chk("stall_ready", req_ready, 0);
        chk("stall_prod", out_product, 6);
        chk("stall_id", out_id, 0);
      end
      if (k == 5) begin
        chk("drain0_prod", out_product, 6);
        chk("drain0_id", out_id, 0);
      end
      if (k == 6) begin
        chk("drain1_ovalid", out_valid, 1);
        chk("drain1_prod", out_product, 20);
        chk("drain1_id", out_id, 1);
      end
      if (k == 7) begin
        chk("drain_done_ovalid", out_valid, 0);
        chk("drain_done_occ", occupancy, 0);
      end
      tick();
    end

    // Reset with the pipeline full.
    do_reset();
    set_ops(0, 4'd5, 4'd5);
    set_ops(1, 4'd6, 4'd6);
    req_valid = 4'b0011;
    out_ready = 1'b0;
    tick();
    tick();
    #1;
    chk("mid_occ_full", occupancy, 2);
    rst_n = 1'b0;
    #1;
    chk("mid_ovalid", out_valid, 0);
    chk("mid_prod", out_product, 0);
    chk("mid_id", out_id, 0);
    chk("mid_occ", occupancy, 0);
    chk("mid_ready", req_ready, 0);
    req_valid = '0;
    out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("mid_stale_ovalid", out_valid, 0);
    end

    // Requesters 1 and 3 held high.
    do_reset();
    req_valid = 4'b1010;
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
`ifdef MULT4U_SHARE_ARB_FIXED_PRIO_EN
      chk("prio_ready", req_ready, 4'b0010);
`else
      chk("prio_ready", req_ready, (k % 2 == 0) ? 4'b0010 : 4'b1000);
`endif
      tick();
    end
    req_valid = '0;
    tick();
    tick();
    tick();

    // Randomized run against an in-order transaction model.
    do_reset();
    exp_q.delete();
    ptr = 0;
    acc_last = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      req_valid        = N'($urandom_range(0, 15) & $urandom_range(0, 15));
      req_multiplicand = 16'($urandom);
      req_multiplier   = 16'($urandom);
      out_ready        = ($urandom_range(0, 3) != 0);
      #1;
      n = exp_q.size();
      exp_ov = (n == 2 || (n == 1 && !acc_last)) ? 1 : 0;
      allowed = (n < 2 || out_ready) ? 1 : 0;
      found = 0;
      w = 0;
      for (int i = 0; i < N; i++) begin
        idx = (ptr + i) % N;
        if (!found && req_valid[idx]) begin
          found = 1;
          w = idx;
        end
      end
      exp_ready = (found && allowed) ? (N'(1) << w) : '0;
      chk("rnd_occ", occupancy, n);
      chk("rnd_ovalid", out_valid, exp_ov);
      chk("rnd_ready", req_ready, exp_ready);
      if (exp_ov) begin
        chk("rnd_id", out_id, exp_q[0].id);
        chk("rnd_prod", out_product, exp_q[0].prod);
        if (out_ready) void'(exp_q.pop_front());
      end
      if (found && allowed) begin
        exp_q.push_back('{w, int'(req_multiplicand[w*4 +: 4]) * int'(req_multiplier[w*4 +: 4])});
`ifndef MULT4U_SHARE_ARB_FIXED_PRIO_EN
        ptr = (w + 1) % N;
`endif
        acc_last = 1;
      end else begin
        acc_last = 0;
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mult4u_share_arb.md
MULT4U_SHARE_ARB -- requirements
Module: mult4u_share_arb

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters sharing one 4x4 unsigned multiplier (legal 2..8).
REQ-002 SHALL have derived localparam ID_W, clog2(NUM_REQ), requester-index width.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset; asynchronous and active-low.
REQ-005 SHALL have port req_valid, input, NUM_REQ, per-requester operand-valid.
REQ-006 SHALL have port req_ready, output, NUM_REQ, per-requester accept; at most one bit high per cycle.
REQ-007 SHALL have port req_multiplicand, input, 4*NUM_REQ, packed; slice i belongs to requester i.
REQ-008 SHALL have port req_multiplier, input, 4*NUM_REQ, packed; slice i belongs to requester i.
REQ-009 SHALL have port out_valid, output, 1, result valid.
REQ-010 SHALL have port out_ready, input, 1, result consumer accept.
REQ-011 SHALL have port out_product, output, 8, unsigned product.
REQ-012 SHALL have port out_id, output, ID_W, index of the requester that issued the result.
REQ-013 SHALL have port occupancy, output, 2, number of valid pipeline stages (0..2).

Function
REQ-014 SHALL implement a two-stage pipeline: S1 holds registered operands plus id; S2 holds the registered 8-bit product plus id.
- Handshake: a transfer occurs on req_valid[i] & req_ready[i]; a result transfer occurs on out_valid & out_ready.
REQ-015 SHALL compute advance terms: s2_adv = !s2_valid | out_ready; s1_adv = !s1_valid | s2_adv.
REQ-016 SHALL drive req_ready[i] = grant[i] & s1_adv, where grant is a combinational one-hot selection among the asserted req_valid bits.
REQ-017 SHALL produce an accepted request on out_valid exactly 2 cycles after acceptance when out_ready stays high.
- Back-to-back acceptance at full throughput yields 1 result per cycle.
REQ-018 SHALL stall the pipeline while out_valid & !out_ready.
- S2 holds and out_product/out_id are stable.
- S1 holds if valid.
- All req_ready stay low while S1 is full and stalled.
REQ-019 SHALL use round-robin arbitration (macro absent).
- Pointer rr starts at 0.
- Search order is rr, rr+1, ... mod NUM_REQ.
- After an accepted grant to index i, rr becomes (i+1) mod NUM_REQ.
- rr is unchanged when nothing is accepted.
REQ-020 SHALL compute out_product = multiplicand * multiplier, unsigned, full 8 bits with no truncation (15*15 = 225).
REQ-021 SHALL not require req_valid to stay high after a non-accepted cycle; a dropped request is simply not served.
REQ-022 SHALL capture operands only from the granted slice at the accept edge; later changes on that slice have no effect.
REQ-023 SHALL update occupancy the same cycle as each stage's valid.
- Simultaneous accept and output transfer at occupancy 2 keeps occupancy at 2.

Reset
REQ-024 SHALL, on rst_n low, asynchronously clear s1_valid, s2_valid, rr, S2 product and ids.
- Resulting outputs: out_valid=0, out_product=0, out_id=0, occupancy=0, req_ready=0 during reset.
REQ-025 SHALL discard in-flight operations when reset asserts mid-operation; no result for them appears after release.
REQ-026 SHALL allow acceptance on the first rising edge after rst_n deasserts.

Configuration
REQ-027 SHALL select fixed priority when MULT4U_SHARE_ARB_FIXED_PRIO_EN is defined.
- The lowest asserted index wins.
- The rr register is not built.
REQ-028 SHALL use round-robin per REQ-019 when MULT4U_SHARE_ARB_FIXED_PRIO_EN is not defined.

Structure
REQ-029 SHALL place the following in shared package mult4u_share_arb_pkg:
- operand width constant (4)
- product width constant (8)
- a stage struct typedef: valid, id, operands/product
REQ-030 SHALL instantiate exactly one mult4u_booth4_sklansky between S1 and S2, fed from S1 registers.
- Arbitration stays inline; no other sub-modules.

Verification
REQ-031 SHALL cover single request: req 2 with 4'd7 x 4'd9, out_ready=1 -> out_valid 2 cycles later, product 63, id 2.
REQ-032 SHALL cover all four requesting continuously (round-robin), with req i operands (i+3, i+5) -> grant order 0,1,2,3,0.
- Products 15, 24, 35, 48; one result per cycle.
REQ-033 SHALL cover stall: out_ready=0 for 5 cycles with two requests queued.
- occupancy reaches 2, req_ready all 0, out_product stable.
- Release yields both results in order with no loss or duplication.
REQ-034 SHALL cover corner arithmetic: 15x15 -> 225; 0x15 -> 0; 1x1 -> 1.
REQ-035 SHALL cover reset mid-flight: assert rst_n low with occupancy 2 -> outputs zero immediately; no stale result after release.
REQ-036 SHALL cover the macro-defined build with reqs 1 and 3 held -> req 1 always granted and req 3 starves.
